move_input_encoder: RTL and testbench



---
 rtl/move_input_encoder_pkg.sv | 23 ++
 rtl/move_input_encoder_button_debounce.sv | 51 +++++
 rtl/move_input_encoder.sv | 98 +++++++++
 tb/tb_move_input_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/move_input_encoder_pkg.sv
// Shared move-code and FSM-state definitions for the move input encoder.
// The GO_* codes are also decoded by the game FSM and the board logic.
package move_input_encoder_pkg;

    localparam logic [2:0] GO_NONE  = 3'b000;
    localparam logic [2:0] GO_UP    = 3'b001;
    localparam logic [2:0] GO_DOWN  = 3'b010;
    localparam logic [2:0] GO_LEFT  = 3'b011;
    localparam logic [2:0] GO_RIGHT = 3'b100;

    // Bit positions of each button inside btn_n / btn_level.
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } enc_state_t;

endpackage

// File: rtl/move_input_encoder_button_debounce.sv
// One push-button channel: two-flop synchroniser on the inverted raw input,
// followed by a counter that only accepts a new level after it has been
// seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
module move_input_encoder_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Bring the active-high button level into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; any bounce back restarts the count,
    // and the counter never exceeds CNT_LAST so it cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_level = r_stable;

endmodule

// File: rtl/move_input_encoder.sv
// Move input encoder: debounces four active-low buttons and turns each new
// press into a single-cycle 3-bit move code, then waits for a full release.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | all buttons released; waiting for a debounced press
//   EMIT  | go carries the latched move code for this one cycle
//   HOLD  | press consumed (or swallowed while disabled); wait for release
module move_input_encoder
    import move_input_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn_n,
    output logic [2:0] go,
    output logic [3:0] btn_level
);

    logic [3:0] w_level;
    logic       w_pressed;
    logic [2:0] w_code;

    enc_state_t r_state;
    logic [2:0] r_go;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        move_input_encoder_button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_btn_n (btn_n[g]),
            .o_level (w_level[g])
        );
    end

    assign w_pressed = |w_level;

    // Priority encode the debounced levels: up > down > left > right.
    always_comb begin
        w_code = GO_NONE;
        if (w_level[BTN_UP]) begin
            w_code = GO_UP;
        end else if (w_level[BTN_DOWN]) begin
            w_code = GO_DOWN;
        end else if (w_level[BTN_LEFT]) begin
            w_code = GO_LEFT;
        end else if (w_level[BTN_RIGHT]) begin
            w_code = GO_RIGHT;
        end
    end

    // Press/release sequencer; go is loaded on entry to EMIT so it is high
    // exactly while the FSM sits in EMIT, and a late enable drop cannot cancel it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_go    <= GO_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_go <= GO_NONE;
                    if (w_pressed) begin
                        if (enable) begin
                            r_go    <= w_code;
                            r_state <= ST_EMIT;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_EMIT: begin
                    r_go    <= GO_NONE;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_go <= GO_NONE;
                    if (!w_pressed) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_go    <= GO_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign go        = r_go;
    assign btn_level = w_level;

endmodule

// File: tb/tb_move_input_encoder.sv
// Self-checking bench for move_input_encoder with a short debounce window.
module tb_move_input_encoder;

    localparam int D     = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn_n;
    logic [2:0] go;
    logic [3:0] btn_level;

    move_input_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .btn_n     (btn_n),
        .go        (go),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: raw-press delay line, debounced levels, and a
    // "one code per press, then wait for full release" tracker.
    logic [3:0] m_pipe[$];
    logic [3:0] m_stable;
    int         m_run[4];
    logic [2:0] m_go;
    bit         m_armed;      // ready to accept a new press
    bit         m_just_sent;  // code went out on the last edge

    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse_cyc = 0;
    logic [2:0] last_code = 3'b000;

    function automatic logic [2:0] move_of(input logic [3:0] lvl);
        if (lvl[3]) return 3'b001;
        if (lvl[2]) return 3'b010;
        if (lvl[1]) return 3'b011;
        if (lvl[0]) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_clear();
        m_pipe.delete();
        m_pipe.push_back(4'b0000);
        m_pipe.push_back(4'b0000);
        m_stable    = 4'b0000;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_go        = 3'b000;
        m_armed     = 1'b1;
        m_just_sent = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        logic [3:0] lvl;
        if (reset) begin
            model_clear();
            return;
        end
        lvl  = m_stable;
        seen = m_pipe.pop_front();
        m_pipe.push_back(~btn_n);
        // move tracker
        m_go = 3'b000;
        if (m_just_sent) begin
            m_just_sent = 1'b0;
        end else if (m_armed) begin
            if (lvl != 4'b0000) begin
                m_armed = 1'b0;
                if (enable) begin
                    m_go        = move_of(lvl);
                    m_just_sent = 1'b1;
                end
            end
        end else if (lvl == 4'b0000) begin
            m_armed = 1'b1;
        end
        // debounce: accept a level after D consecutive disagreeing samples
        for (int i = 0; i < 4; i++) begin
            if (seen[i] == m_stable[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_stable[i] = seen[i];
                    m_run[i]    = 0;
                end
            end
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        total++;
        assert (go === m_go) else begin
            bad++;
            $error("FAIL go cyc=%0d observed=%b expected=%b", cyc, go, m_go);
        end
        total++;
        assert (btn_level === m_stable) else begin
            bad++;
            $error("FAIL btn_level cyc=%0d observed=%b expected=%b", cyc, btn_level, m_stable);
        end
        if (go !== 3'b000) begin
            pulses++;
            last_pulse_cyc = cyc;
            last_code      = go;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int p0;
    int t0;
    int hold;

    initial begin
        model_clear();
        reset  = 1'b1;
        enable = 1'b0;
        btn_n  = 4'b1111;

        // reset state
        steps(3);
        reset = 1'b0;
        steps(4);
        check_int("no_pulse_after_reset", pulses, 0);

        // clean press of up
        enable = 1'b1;
        p0 = pulses;
        t0 = cyc;
        btn_n = 4'b0111;
        steps(20);
        check_int("clean_pulses", pulses - p0, 1);
        check_int("clean_latency", last_pulse_cyc - t0, 7);
        check_int("clean_code", int'(last_code), 1);
        btn_n = 4'b1111;
        steps(12);
        check_int("clean_release_quiet", pulses - p0, 1);

        // bounce on left, then steady low
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            btn_n = (i % 2 == 0) ? 4'b1101 : 4'b1111;
            steps(2);
        end
        check_int("bounce_no_pulse", pulses - p0, 0);
        btn_n = 4'b1101;
        t0 = cyc;
        steps(20);
        check_int("bounce_pulses", pulses - p0, 1);
        check_int("bounce_latency", last_pulse_cyc - t0, 7);
        check_int("bounce_code", int'(last_code), 3);
        btn_n = 4'b1111;
        steps(12);

        // simultaneous down+right, then left added: down wins
        p0 = pulses;
        btn_n = 4'b1010;
        steps(10);
        btn_n = 4'b1000;
        steps(8);
        check_int("simul_pulses", pulses - p0, 1);
        check_int("simul_code", int'(last_code), 2);
        btn_n = 4'b1011;
        steps(6);
        btn_n = 4'b1010;
        steps(10);
        check_int("hold_ignores_second", pulses - p0, 1);
        btn_n = 4'b1111;
        steps(12);
        btn_n = 4'b1110;
        steps(10);
        check_int("right_after_release", pulses - p0, 2);
        check_int("right_code", int'(last_code), 4);
        btn_n = 4'b1111;
        steps(12);

        // enable gating
        p0 = pulses;
        enable = 1'b0;
        btn_n = 4'b0111;
        steps(12);
        enable = 1'b1;
        steps(6);
        check_int("disabled_swallowed", pulses - p0, 0);
        btn_n = 4'b1111;
        steps(12);
        btn_n = 4'b1101;
        steps(10);
        check_int("enabled_left", pulses - p0, 1);
        check_int("enabled_left_code", int'(last_code), 3);
        btn_n = 4'b1111;
        steps(12);

        // reset while holding down in HOLD
        p0 = pulses;
        btn_n = 4'b1011;
        steps(12);
        reset = 1'b1;
        step();
        check_int("rst_go", int'(go), 0);
        check_int("rst_level", int'(btn_level), 0);
        reset = 1'b0;
        t0 = cyc;
        steps(12);
        check_int("rst_repress_pulses", pulses - p0, 2);
        check_int("rst_repress_latency", last_pulse_cyc - t0, 7);
        check_int("rst_repress_code", int'(last_code), 2);
        btn_n = 4'b1111;
        steps(12);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            btn_n  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            reset  = ($urandom_range(0, 79) == 0);
            hold   = int'($urandom_range(1, 9));
            steps(hold);
            reset  = 1'b0;
        end
        btn_n = 4'b1111;
        steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
